// File: rtl/vga_sync_out_if.sv
// Renderer-facing bundle of the VGA timing/output stage: pixel position,
// strobes and the registered TinyVGA pin byte, plus the renderer's colour.
interface vga_sync_out_if;
    logic [5:0] rgb_in;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
    logic [7:0] vga_out;

    modport master (
        input  rgb_in,
        output hpos,
        output vpos,
        output display_on,
        output line_start,
        output frame_start,
        output frame_count,
        output vga_out
    );

    modport slave (
        output rgb_in,
        input  hpos,
        input  vpos,
        input  display_on,
        input  line_start,
        input  frame_start,
        input  frame_count,
        input  vga_out
    );
endinterface

// File: rtl/vga_sync_out.sv
// 640x480@60 timing generator and registered RGB222 + sync output stage
// driving the TinyVGA Pmod pin order {hs,B0,G0,R0,vs,B1,G1,R1}.
module vga_sync_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    vga_sync_out_if.master    vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Blank pixel with both syncs at their inactive pin level.
    localparam logic [7:0] IDLE_PINS  = {SYNC_NEG, 3'b000, SYNC_NEG, 3'b000};

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic [7:0] r_frame_count;
    logic [7:0] r_vga_out;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_display_on;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_hs_pin;
    logic       w_vs_pin;
    logic [5:0] w_colour;
    logic [7:0] w_pins;

    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt        <= 10'd0;
            r_vcnt        <= 10'd0;
            r_frame_count <= 8'd0;
        end else if (ena) begin
            if (w_h_last) begin
                r_hcnt <= 10'd0;
                if (w_v_last) begin
                    r_vcnt        <= 10'd0;
                    r_frame_count <= r_frame_count + 8'd1;
                end else begin
                    r_vcnt <= r_vcnt + 10'd1;
                end
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    assign w_display_on = (r_hcnt < H_VIS_END) && (r_vcnt < V_VIS_END);
    assign w_hs_raw     = (r_hcnt >= HS_BEGIN) && (r_hcnt < HS_END);
    assign w_vs_raw     = (r_vcnt >= VS_BEGIN) && (r_vcnt < VS_END);
    assign w_hs_pin     = w_hs_raw ^ SYNC_NEG;
    assign w_vs_pin     = w_vs_raw ^ SYNC_NEG;

    // rgb_in is {R1,R0,G1,G0,B1,B0}; blanking zeroes colour outside the visible area.
    assign w_colour = w_display_on ? vga.rgb_in : 6'd0;
    assign w_pins   = {w_hs_pin, w_colour[0], w_colour[2], w_colour[4],
                       w_vs_pin, w_colour[1], w_colour[3], w_colour[5]};

    // Syncs and colour are captured together so they leave on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_out <= IDLE_PINS;
        end else if (ena) begin
            r_vga_out <= w_pins;
        end else begin
            r_vga_out <= IDLE_PINS;
        end
    end

    assign vga.hpos        = r_hcnt;
    assign vga.vpos        = r_vcnt;
    assign vga.display_on  = w_display_on;
    assign vga.line_start  = ena && (r_hcnt == 10'd0);
    assign vga.frame_start = ena && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    assign vga.frame_count = r_frame_count;
    assign vga.vga_out     = r_vga_out;

endmodule

// File: tb/tb_vga_sync_out.sv
// Bench for vga_sync_out: a default-timing instance plus a shrunken,
// active-high-sync instance so frame-level behaviour fits a short run.
module tb_vga_sync_out;

    logic clk;
    logic rst_n;
    logic ena;

    vga_sync_out_if if_a ();
    vga_sync_out_if if_b ();

    vga_sync_out u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .vga   (if_a)
    );

    vga_sync_out #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2),
        .SYNC_NEG (1'b0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .vga   (if_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int t        = 0;   // enabled cycles since reset release
    int cyc      = 0;
    logic [7:0] last_vga_a, last_vga_b;
    logic       last_ls_a, last_fs_b;
    logic [31:0] exp_q[$];

    typedef struct {
        int         h;
        int         v;
        logic [5:0] rgb;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Pin byte straight from the timing rules: visible window, sync windows, polarity.
    function automatic logic [7:0] pins(input int h, input int v,
                                        input int hact, input int hfp, input int hsw,
                                        input int vact, input int vfp, input int vsw,
                                        input bit neg, input logic [5:0] rgb);
        logic [5:0] c;
        bit hr, vr;
        c  = (h < hact && v < vact) ? rgb : 6'd0;
        hr = (h >= hact + hfp) && (h < hact + hfp + hsw);
        vr = (v >= vact + vfp) && (v < vact + vfp + vsw);
        return {hr ^ neg, c[0], c[2], c[4], vr ^ neg, c[1], c[3], c[5]};
    endfunction

    function automatic int ha(); return t % 800; endfunction
    function automatic int va(); return (t / 800) % 525; endfunction
    function automatic int fa(); return (t / 420000) % 256; endfunction
    function automatic int hb(); return t % 16; endfunction
    function automatic int vb(); return (t / 16) % 9; endfunction
    function automatic int fb(); return (t / 144) % 256; endfunction

    // ---------------- driver: one clock, entered and left at negedge ----------------
    task automatic step(input bit en, input logic [5:0] ra, input logic [5:0] rb);
        logic [7:0] ea, eb;
        ena         = en;
        if_a.rgb_in = ra;
        if_b.rgb_in = rb;
        #1;
        chk("hpos_a",  32'(if_a.hpos),        32'(ha()));
        chk("vpos_a",  32'(if_a.vpos),        32'(va()));
        chk("disp_a",  32'(if_a.display_on),  32'(ha() < 640 && va() < 480));
        chk("ls_a",    32'(if_a.line_start),  32'(en && ha() == 0));
        chk("fs_a",    32'(if_a.frame_start), 32'(en && ha() == 0 && va() == 0));
        chk("fcnt_a",  32'(if_a.frame_count), 32'(fa()));
        chk("hpos_b",  32'(if_b.hpos),        32'(hb()));
        chk("vpos_b",  32'(if_b.vpos),        32'(vb()));
        chk("disp_b",  32'(if_b.display_on),  32'(hb() < 8 && vb() < 4));
        chk("ls_b",    32'(if_b.line_start),  32'(en && hb() == 0));
        chk("fs_b",    32'(if_b.frame_start), 32'(en && hb() == 0 && vb() == 0));
        chk("fcnt_b",  32'(if_b.frame_count), 32'(fb()));
        last_ls_a = if_a.line_start;
        last_fs_b = if_b.frame_start;
        ea = en ? pins(ha(), va(), 640, 16, 96, 480, 10, 2, 1'b1, ra) : 8'h88;
        eb = en ? pins(hb(), vb(), 8, 2, 3, 4, 1, 2, 1'b0, rb) : 8'h00;
        @(posedge clk);
        if (en) t++;
        cyc++;
        @(negedge clk);
        chk("vga_a", 32'(if_a.vga_out), 32'(ea));
        chk("vga_b", 32'(if_b.vga_out), 32'(eb));
        last_vga_a = if_a.vga_out;
        last_vga_b = if_b.vga_out;
    endtask

    task automatic step_rand(input bit en);
        step(en, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    endtask

    task automatic seek_a(input int h, input int v, input int max_cycles);
        int n = 0;
        while (!(ha() == h && (v < 0 || va() == v))) begin
            step_rand(1'b1);
            n++;
            if (n > max_cycles) begin
                chk("seek_timeout", 32'(n), 32'(max_cycles));
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lows, first_low, highs;

        tbl[0] = '{h: 0,   v: 0, rgb: 6'h3F, exp: 8'hFF};
        tbl[1] = '{h: 639, v: 0, rgb: 6'h15, exp: 8'hF8};
        tbl[2] = '{h: 640, v: 0, rgb: 6'h3F, exp: 8'h88};
        tbl[3] = '{h: 655, v: 0, rgb: 6'h3F, exp: 8'h88};
        tbl[4] = '{h: 656, v: 0, rgb: 6'h00, exp: 8'h08};
        tbl[5] = '{h: 751, v: 0, rgb: 6'h3F, exp: 8'h08};
        tbl[6] = '{h: 752, v: 0, rgb: 6'h3F, exp: 8'h88};
        tbl[7] = '{h: 0,   v: 1, rgb: 6'h2A, exp: 8'h8F};
        tbl[8] = '{h: 5,   v: 2, rgb: 6'h24, exp: 8'hA9};

        rst_n       = 1'b1;
        ena         = 1'b0;
        if_a.rgb_in = 6'd0;
        if_b.rgb_in = 6'd0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state while held
        chk("rst_vga_a",  32'(if_a.vga_out),     32'h88);
        chk("rst_hpos_a", 32'(if_a.hpos),        32'd0);
        chk("rst_vpos_a", 32'(if_a.vpos),        32'd0);
        chk("rst_fcnt_a", 32'(if_a.frame_count), 32'd0);
        chk("rst_disp_a", 32'(if_a.display_on),  32'd1);
        chk("rst_vga_b",  32'(if_b.vga_out),     32'h00);
        rst_n = 1'b1;
        t = 0;

        // Table-driven pixel/sync vectors on the default-timing instance
        for (int i = 0; i < 9; i++) begin
            seek_a(tbl[i].h, tbl[i].v, 2000);
            step(1'b1, tbl[i].rgb, 6'($urandom_range(0, 63)));
            chk($sformatf("tbl%0d", i), 32'(last_vga_a), 32'(tbl[i].exp));
        end

        // One full line: hsync low width/position and line_start period
        seek_a(0, -1, 900);
        lows = 0;
        first_low = -1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd800);
        for (int i = 0; i <= 800; i++) begin
            step_rand(1'b1);
            if (i < 800 && !last_vga_a[7]) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
            if (last_ls_a) begin
                if (exp_q.size() > 0) chk("ls_period", 32'(i), exp_q.pop_front());
                else chk("ls_extra", 32'(i), 32'hFFFF_FFFF);
            end
        end
        chk("hs_width", 32'(lows), 32'd96);
        chk("hs_first", 32'(first_low), 32'd656);
        chk("ls_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Small instance: one frame of vsync (active-high pins) and frame_start period
        while (t % 144 != 0) step_rand(1'b1);
        highs = 0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd144);
        for (int i = 0; i <= 144; i++) begin
            step_rand(1'b1);
            if (i < 144 && last_vga_b[3]) highs++;
            if (last_fs_b) begin
                if (exp_q.size() > 0) chk("fs_period", 32'(i), exp_q.pop_front());
                else chk("fs_extra", 32'(i), 32'hFFFF_FFFF);
            end
        end
        chk("vs_width_b", 32'(highs), 32'd32);
        chk("fs_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Randomised ena pattern
        for (int i = 0; i < 1500; i++) step_rand(($urandom_range(0, 3) != 0));

        // frame_count wrap 255 -> 0 on the small instance
        while (t < 256 * 144 - 1) step_rand(1'b1);
        chk("fcnt_b_255", 32'(if_b.frame_count), 32'd255);
        step_rand(1'b1);
        chk("fcnt_b_wrap", 32'(if_b.frame_count), 32'd0);
        chk("fcnt_a_none", 32'(if_a.frame_count), 32'd0);

        // ena low for 50 cycles at hpos 100, then resume
        seek_a(100, -1, 900);
        for (int i = 0; i < 50; i++) step_rand(1'b0);
        chk("hold_hpos", 32'(if_a.hpos), 32'd100);
        chk("hold_vga",  32'(last_vga_a), 32'h88);
        step_rand(1'b1);
        chk("resume_hpos", 32'(if_a.hpos), 32'd101);

        // Asynchronous reset mid-line
        seek_a(400, -1, 900);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vga_a", 32'(if_a.vga_out), 32'h88);
        chk("mid_rst_vga_b", 32'(if_b.vga_out), 32'h00);
        chk("mid_rst_hpos",  32'(if_a.hpos),    32'd0);
        chk("mid_rst_vpos",  32'(if_a.vpos),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        step_rand(1'b1);
        chk("post_rst_ls", 32'(last_ls_a), 32'd1);
        for (int i = 0; i < 20; i++) step_rand(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
